// File: rtl/handshake_arbiter.sv
// handshake_arbiter
//
// Round-robin arbiter that hands a shared resource to one of N requesters
// at a time and then waits for the resource to acknowledge the transaction.
// A grant is abandoned after TIMEOUT cycles without an acknowledge, and
// abandoned transactions are tallied in a saturating error counter.
//
// Ports:
//   clk      - clock, all state updates on the rising edge
//   rst      - synchronous active-high reset
//   req      - per-requester request level (N bits)
//   ready    - resource can accept a new transaction (sampled only in IDLE)
//   readyp   - resource acknowledges the current transaction (sampled only in GRANT)
//   gnt      - one-hot grant, zero outside GRANT
//   grant_id - binary index of the granted requester, holds when gnt is zero
//   busy     - high while in GRANT
//   done     - one-cycle pulse after an acknowledged transaction
//   timeout  - one-cycle pulse after an abandoned transaction
//   err_cnt  - saturating count of timeouts
//
// Every output comes straight from a register, so no input reaches an
// output combinationally.

module handshake_arbiter #(
    parameter int N       = 4,
    parameter int TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         ready,
    input  logic         readyp,
    output logic [N-1:0] gnt,
    output logic [2:0]   grant_id,
    output logic         busy,
    output logic         done,
    output logic         timeout,
    output logic [7:0]   err_cnt
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t       state_q, state_d;
    logic [N-1:0] gnt_q, gnt_d;
    logic [2:0]   grantId_q, grantId_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         timeout_q, timeout_d;
    logic [7:0]   errCnt_q, errCnt_d;
    logic [7:0]   waitCnt_q, waitCnt_d;
    logic [2:0]   last_q, last_d;

    logic         winnerFound;
    logic [2:0]   winnerIdx;

    // Round-robin search: start one past the last granted index and wrap,
    // taking the first active request. Requester 0 wins first out of reset
    // because last resets to N-1.
    always_comb begin : rrSearch
        int idx;
        winnerFound = 1'b0;
        winnerIdx   = '0;
        idx         = 0;
        for (int i = 1; i <= N; i++) begin
            idx = (int'(last_q) + i) % N;
            if (!winnerFound && req[idx]) begin
                winnerFound = 1'b1;
                winnerIdx   = 3'(idx);
            end
        end
    end

    // Next-state and next-output logic. Pulses default low so they last a
    // single cycle; every other register holds unless a transition updates it.
    // Leaving GRANT always lands in IDLE, which guarantees at least one
    // cycle with gnt low before the next grant.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        grantId_d = grantId_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        timeout_d = 1'b0;
        errCnt_d  = errCnt_q;
        waitCnt_d = waitCnt_q;
        last_d    = last_q;

        case (state_q)
            IDLE: begin
                if (ready && winnerFound) begin
                    state_d   = GRANT;
                    gnt_d     = {{(N-1){1'b0}}, 1'b1} << winnerIdx;
                    grantId_d = winnerIdx;
                    busy_d    = 1'b1;
                    waitCnt_d = '0;
                end
            end
            GRANT: begin
                // An acknowledge wins over a simultaneous timeout.
                if (readyp) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    last_d  = grantId_q;
                end else if (waitCnt_q == 8'(TIMEOUT - 1)) begin
                    state_d   = IDLE;
                    gnt_d     = '0;
                    busy_d    = 1'b0;
                    timeout_d = 1'b1;
                    last_d    = grantId_q;
                    if (errCnt_q != 8'hFF) begin
                        errCnt_d = errCnt_q + 8'd1;
                    end
                end else begin
                    waitCnt_d = waitCnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous reset overriding all inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            grantId_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            errCnt_q  <= '0;
            waitCnt_q <= '0;
            last_q    <= 3'(N - 1);
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            grantId_q <= grantId_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            errCnt_q  <= errCnt_d;
            waitCnt_q <= waitCnt_d;
            last_q    <= last_d;
        end
    end

    assign gnt      = gnt_q;
    assign grant_id = grantId_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign timeout  = timeout_q;
    assign err_cnt  = errCnt_q;

endmodule

// File: tb/tb_handshake_arbiter.sv
// tb_handshake_arbiter
//
// Directed bench for handshake_arbiter with N=4, TIMEOUT=16. A table of
// single-cycle vectors covers round-robin order, ready gating, readyp in
// IDLE, request drops during GRANT and reset; hand-written sequences cover
// the timeout length, acknowledge/timeout coincidence, reset mid-grant and
// error counter saturation.

module tb_handshake_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       ready;
    logic       readyp;
    logic [3:0] gnt;
    logic [2:0] grant_id;
    logic       busy;
    logic       done;
    logic       timeout;
    logic [7:0] err_cnt;

    int checks;
    int passes;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       ready;
        logic       readyp;
        logic [3:0] gnt;
        logic [2:0] id;
        logic       busy;
        logic       done;
        logic       tmo;
        logic [7:0] err;
    } vec_t;

    vec_t vecs[$];

    handshake_arbiter #(
        .N       (4),
        .TIMEOUT (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .ready    (ready),
        .readyp   (readyp),
        .gnt      (gnt),
        .grant_id (grant_id),
        .busy     (busy),
        .done     (done),
        .timeout  (timeout),
        .err_cnt  (err_cnt)
    );

    // 10 time-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive inputs, take one rising edge, then settle 1 unit past it so
    // outputs are sampled away from the edge.
    task automatic applyStimulus(input logic r, input logic [3:0] rq,
                                 input logic rdy, input logic rdyp);
        rst    = r;
        req    = rq;
        ready  = rdy;
        readyp = rdyp;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [3:0] eg,
                               input logic [2:0] eid, input logic eb,
                               input logic ed, input logic et,
                               input logic [7:0] ee);
        checks++;
        if ({gnt, grant_id, busy, done, timeout, err_cnt} === {eg, eid, eb, ed, et, ee}) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got gnt=%b id=%0d busy=%b done=%b tmo=%b err=%0d, expected gnt=%b id=%0d busy=%b done=%b tmo=%b err=%0d",
                     name, gnt, grant_id, busy, done, timeout, err_cnt,
                     eg, eid, eb, ed, et, ee);
        end
    endtask

    task automatic checkValue(input string name, input int act, input int exp);
        checks++;
        if (act == exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic addVec(input logic r, input logic [3:0] rq, input logic rdy,
                          input logic rdyp, input logic [3:0] eg,
                          input logic [2:0] eid, input logic eb,
                          input logic ed, input logic et, input logic [7:0] ee);
        vec_t v;
        v.rst = r;    v.req = rq;  v.ready = rdy; v.readyp = rdyp;
        v.gnt = eg;   v.id = eid;  v.busy = eb;   v.done = ed;
        v.tmo = et;   v.err = ee;
        vecs.push_back(v);
    endtask

    initial begin
        int busyCycles;
        int stepsLeft;
        bit expired;

        checks = 0;
        passes = 0;
        rst    = 1'b1;
        req    = '0;
        ready  = 1'b0;
        readyp = 1'b0;

        //      rst req     rdy rdyp  gnt     id busy done tmo err
        addVec(1, 4'b0000, 0, 0,   4'b0000, 0, 0, 0, 0, 0);  // reset state
        // all four requesting: 0,1,2,3,0 with a gap after each done
        addVec(0, 4'b1111, 1, 0,   4'b0001, 0, 1, 0, 0, 0);
        addVec(0, 4'b1111, 1, 0,   4'b0001, 0, 1, 0, 0, 0);
        addVec(0, 4'b1111, 1, 1,   4'b0000, 0, 0, 1, 0, 0);
        addVec(0, 4'b1111, 1, 0,   4'b0010, 1, 1, 0, 0, 0);
        addVec(0, 4'b1111, 1, 0,   4'b0010, 1, 1, 0, 0, 0);
        addVec(0, 4'b1111, 1, 1,   4'b0000, 1, 0, 1, 0, 0);
        addVec(0, 4'b1111, 1, 0,   4'b0100, 2, 1, 0, 0, 0);
        addVec(0, 4'b1111, 1, 0,   4'b0100, 2, 1, 0, 0, 0);
        addVec(0, 4'b1111, 1, 1,   4'b0000, 2, 0, 1, 0, 0);
        addVec(0, 4'b1111, 1, 0,   4'b1000, 3, 1, 0, 0, 0);
        addVec(0, 4'b1111, 1, 0,   4'b1000, 3, 1, 0, 0, 0);
        addVec(0, 4'b1111, 1, 1,   4'b0000, 3, 0, 1, 0, 0);
        addVec(0, 4'b1111, 1, 0,   4'b0001, 0, 1, 0, 0, 0);
        addVec(0, 4'b1111, 1, 1,   4'b0000, 0, 0, 1, 0, 0);
        // readyp ignored in IDLE, no requests
        addVec(0, 4'b0000, 1, 1,   4'b0000, 0, 0, 0, 0, 0);
        // ready low holds off a pending request
        for (int i = 0; i < 5; i++) begin
            addVec(0, 4'b0100, 0, 0, 4'b0000, 0, 0, 0, 0, 0);
        end
        addVec(0, 4'b0100, 1, 0,   4'b0100, 2, 1, 0, 0, 0);
        // ready ignored, other requests deferred, granted requester drops req
        addVec(0, 4'b0011, 0, 0,   4'b0100, 2, 1, 0, 0, 0);
        addVec(0, 4'b0000, 0, 0,   4'b0100, 2, 1, 0, 0, 0);
        addVec(0, 4'b0000, 0, 0,   4'b0100, 2, 1, 0, 0, 0);
        addVec(0, 4'b0000, 0, 0,   4'b0100, 2, 1, 0, 0, 0);
        addVec(0, 4'b0000, 0, 0,   4'b0100, 2, 1, 0, 0, 0);
        addVec(0, 4'b0000, 0, 1,   4'b0000, 2, 0, 1, 0, 0);
        // round-robin skips to 3 after 2
        addVec(0, 4'b1010, 1, 0,   4'b1000, 3, 1, 0, 0, 0);
        // reset one cycle into a grant
        addVec(1, 4'b1010, 1, 0,   4'b0000, 0, 0, 0, 0, 0);
        // single requester granted every time
        addVec(0, 4'b0010, 1, 0,   4'b0010, 1, 1, 0, 0, 0);
        addVec(0, 4'b0010, 1, 1,   4'b0000, 1, 0, 1, 0, 0);
        addVec(0, 4'b0010, 1, 0,   4'b0010, 1, 1, 0, 0, 0);
        addVec(0, 4'b0010, 1, 1,   4'b0000, 1, 0, 1, 0, 0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].req, vecs[i].ready, vecs[i].readyp);
            checkOutput($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].id,
                        vecs[i].busy, vecs[i].done, vecs[i].tmo, vecs[i].err);
        end

        // Timeout: busy lasts exactly 16 cycles, then a one-cycle pulse.
        applyStimulus(0, 4'b0001, 1, 0);
        checkOutput("tmo_grant", 4'b0001, 0, 1, 0, 0, 0);
        busyCycles = 1;
        for (int k = 0; k < 40; k++) begin
            applyStimulus(0, 4'b0001, 0, 0);
            if (busy) busyCycles++;
            else break;
        end
        checkValue("busy_len", busyCycles, 16);
        checkOutput("tmo_pulse", 4'b0000, 0, 0, 0, 1, 1);
        applyStimulus(0, 4'b0001, 0, 0);
        checkOutput("tmo_after", 4'b0000, 0, 0, 0, 0, 1);

        // Acknowledge on the timeout cycle: done wins.
        applyStimulus(0, 4'b0001, 1, 0);
        checkOutput("coin_grant", 4'b0001, 0, 1, 0, 0, 1);
        for (int k = 0; k < 15; k++) begin
            applyStimulus(0, 4'b0001, 0, 0);
        end
        checkOutput("coin_last", 4'b0001, 0, 1, 0, 0, 1);
        applyStimulus(0, 4'b0001, 0, 1);
        checkOutput("coin_done", 4'b0000, 0, 0, 1, 0, 1);

        // Reset three cycles into a grant, then arbitrate immediately.
        applyStimulus(0, 4'b0001, 1, 0);
        checkOutput("rst_grant", 4'b0001, 0, 1, 0, 0, 1);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 4'b0001, 0, 0);
        end
        applyStimulus(1, 4'b0001, 1, 0);
        checkOutput("rst_mid", 4'b0000, 0, 0, 0, 0, 0);
        applyStimulus(0, 4'b1010, 1, 0);
        checkOutput("rst_first", 4'b0010, 1, 1, 0, 0, 0);
        applyStimulus(0, 4'b1010, 0, 1);
        checkOutput("rst_done", 4'b0000, 1, 0, 1, 0, 0);

        // Drive 256 timeouts; the counter must stop at 255.
        expired = 1'b0;
        for (int t = 1; t <= 256 && !expired; t++) begin
            applyStimulus(0, 4'b0001, 1, 0);
            stepsLeft = 20;
            while (!timeout && stepsLeft > 0) begin
                applyStimulus(0, 4'b0001, 0, 0);
                stepsLeft--;
            end
            if (!timeout) begin
                expired = 1'b1;
                checkValue("sat_wait", 0, 1);
            end
            if (t == 1)   checkValue("sat_first", int'(err_cnt), 1);
            if (t == 255) checkValue("sat_255", int'(err_cnt), 255);
            if (t == 256) checkValue("sat_hold", int'(err_cnt), 255);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/handshake_arbiter.md
HANDSHAKE_ARBITER -- requirements
Module: handshake_arbiter

Interface
REQ-001 The block SHALL have parameter N, default 4: number of requesters, legal range 2..8.
REQ-002 The block SHALL have parameter TIMEOUT, default 16: maximum number of cycles in GRANT without an acknowledge, legal range 2..255.
REQ-003 Port clk SHALL be an input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst SHALL be an input, 1 bit: reset, synchronous and active-high.
REQ-005 Port req SHALL be an input, N bits: per-requester request level.
REQ-006 Port ready SHALL be an input, 1 bit: the shared resource can accept a new transaction.
REQ-007 Port readyp SHALL be an input, 1 bit: the resource has completed the current transaction (acknowledge).
REQ-008 Port gnt SHALL be an output, N bits: one-hot grant, or zero.
REQ-009 Port grant_id SHALL be an output, 3 bits: binary index of the granted requester.
REQ-010 Port busy SHALL be an output, 1 bit: high in the GRANT state.
REQ-011 Port done SHALL be an output, 1 bit: one-cycle pulse when a transaction is acknowledged.
REQ-012 Port timeout SHALL be an output, 1 bit: one-cycle pulse when a transaction is abandoned.
REQ-013 Port err_cnt SHALL be an output, 8 bits: saturating count of timeouts.

Function
REQ-014 The block SHALL implement a registered FSM with exactly two states, IDLE and GRANT.
REQ-015 All outputs SHALL be registered; no combinational path SHALL exist from any input to any output.
REQ-016 IDLE SHALL move to GRANT on an edge where ready=1 and req!=0, and SHALL otherwise remain in IDLE.
REQ-017 Arbitration SHALL be round-robin: search from index (last+1) mod N upward with wrap, where last is the most recent granted index (reset value N-1, so requester 0 wins first).
REQ-018 gnt, grant_id and busy SHALL become valid in the cycle after the sampling edge (1-cycle latency) and SHALL stay constant throughout GRANT.
REQ-019 In GRANT, the wait counter SHALL clear on entry and increment by 1 every cycle.
REQ-020 In GRANT, readyp=1 at an edge SHALL clear gnt and busy, pulse done for one cycle, set last to grant_id, and return to IDLE.
REQ-021 In GRANT, reaching counter == TIMEOUT-1 with readyp=0 SHALL clear gnt and busy, pulse timeout for one cycle, increment err_cnt (saturate at 255), set last to grant_id, and return to IDLE.
REQ-022 When readyp=1 and the timeout condition coincide, readyp SHALL take priority: done pulses and timeout does not.
REQ-023 After every GRANT exit the block SHALL spend at least one cycle in IDLE, so gnt is zero for at least one cycle between grants.
REQ-024 readyp SHALL be ignored in IDLE.
REQ-025 ready SHALL be ignored in GRANT.
REQ-026 A granted requester dropping req in GRANT SHALL NOT end the grant; only readyp, timeout or rst end it.
REQ-027 Requests asserted by other requesters during GRANT SHALL be evaluated only at the next IDLE arbitration edge.
REQ-028 With a single active requester, it SHALL be granted on every arbitration.
REQ-029 grant_id SHALL hold its last value when gnt=0.

Reset
REQ-030 rst=1 at an edge SHALL force IDLE, gnt=0, grant_id=0, busy=0, done=0, timeout=0, err_cnt=0, counter=0, last=N-1, and SHALL override all other inputs.
REQ-031 Reset mid-GRANT SHALL drop gnt in the next cycle with no done or timeout pulse.
REQ-032 After rst deasserts, the first arbitration SHALL be possible on the first edge with rst=0.

Verification
REQ-033 Scenario: N=4; ready=1; req=4'b1111 held; readyp pulsed 2 cycles after each grant -> grant_id sequence 0,1,2,3,0; one done per grant; at least one gnt=0 cycle between grants.
REQ-034 Scenario: req=4'b0100; ready=0 for 5 cycles, then ready=1 -> gnt stays 0 while ready=0; gnt=4'b0100 and grant_id=2 one cycle after ready rises.
REQ-035 Scenario: TIMEOUT=16; grant issued; readyp held 0 -> busy high for exactly 16 cycles, then timeout pulse of 1 cycle, err_cnt=1, then IDLE.
REQ-036 Scenario: readyp asserted exactly on the timeout cycle -> done=1, timeout=0, err_cnt unchanged.
REQ-037 Scenario: rst=1 for 1 cycle during GRANT, 3 cycles after grant -> next cycle gnt=0, busy=0, err_cnt=0; with req=4'b1010 afterwards, the first grant goes to requester 1.
REQ-038 Scenario: granted requester drops req mid-GRANT and readyp arrives 4 cycles later -> gnt held until the readyp edge; done pulses once.
